// File: rtl/karaoke_pkg.sv
// Shared PCM types for the karaoke audio path (FIR, sample FIFO, SPI).
package karaoke_pkg;

    localparam int unsigned PCM_W  = 16;
    localparam int unsigned DROP_W = 8;

    typedef logic signed [PCM_W-1:0] pcm_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage : karaoke_pkg

// File: rtl/pcm_fifo_mem.sv
// Sample storage: DEPTH x WIDTH register array, one write port, one asynchronous read port.
module pcm_fifo_mem
    import karaoke_pkg::*;
#(
    parameter int unsigned WIDTH = PCM_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; unread entries are never exposed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : pcm_fifo_mem

// File: rtl/pcm_sample_fifo.sv
// Elastic PCM buffer between decimation FIR and SPI transmitter, drop-oldest on overflow.
module pcm_sample_fifo
    import karaoke_pkg::*;
#(
    parameter int unsigned WIDTH   = PCM_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_sample,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out_sample,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               underrun,
    input  logic               flag_clr,
    output logic [DROP_W-1:0]  drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             drop;
    logic             starve;

    assign empty  = (level == '0);
    assign full   = (level == LEVEL_W'(DEPTH));
    assign push   = in_valid;
    assign pop    = out_valid & out_ready;
    // A push into a full FIFO without a simultaneous pop evicts the oldest sample.
    assign drop   = push & ~pop & full;
    assign starve = out_ready & empty & ~push;

    pcm_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_sample),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer, occupancy, sticky flag and drop counter updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop || drop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop && !full) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !push) begin
                level <= level - LEVEL_W'(1);
            end
            // Set takes priority over clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (flag_clr) begin
                overflow <= 1'b0;
            end
            if (starve) begin
                underrun <= 1'b1;
            end else if (flag_clr) begin
                underrun <= 1'b0;
            end
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    assign out_valid  = ~empty;
    assign out_sample = empty ? '0 : head;

endmodule : pcm_sample_fifo

// File: tb/tb_pcm_sample_fifo.sv
// Directed self-checking bench for pcm_sample_fifo.
module tb_pcm_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_sample;
    logic        in_valid;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        overflow;
    logic        underrun;
    logic        flag_clr;
    logic [7:0]  drop_count;

    int passed = 0;
    int total  = 0;

    pcm_sample_fifo #(
        .WIDTH   (16),
        .DEPTH   (16),
        .LEVEL_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .underrun   (underrun),
        .flag_clr   (flag_clr),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},    32'(out_valid),  32'd0);
        check({tag, "_sample"},   32'(out_sample), 32'd0);
        check({tag, "_level"},    32'(level),      32'd0);
        check({tag, "_overflow"}, 32'(overflow),   32'd0);
        check({tag, "_underrun"}, 32'(underrun),   32'd0);
        check({tag, "_drops"},    32'(drop_count), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_sample = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flag_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: idle after reset
        check_reset_state("t1");

        // 2: single sample round trip
        in_sample = 16'h1234;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_valid",  32'(out_valid),  32'd1);
        check("t2_sample", 32'(out_sample), 32'h1234);
        check("t2_level",  32'(level),      32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_level_after",  32'(level),      32'd0);
        check("t2_sample_after", 32'(out_sample), 32'd0);
        check("t2_valid_after",  32'(out_valid),  32'd0);
        check("t2_no_underrun",  32'(underrun),   32'd0);

        // 3: overfill by 5, drop-oldest, then drain in order
        for (int i = 0; i < 21; i++) begin
            in_sample = 16'(i);
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t3_level",    32'(level),      32'd16);
        check("t3_overflow", 32'(overflow),   32'd1);
        check("t3_drops",    32'(drop_count), 32'd5);
        check("t3_head",     32'(out_sample), 32'h0005);
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", 32'(out_sample), 32'(5 + i));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("t3_empty",    32'(level),    32'd0);
        check("t3_underrun", 32'(underrun), 32'd0);

        // 4: full FIFO with simultaneous push and pop does not drop
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("t4_clr_overflow", 32'(overflow),   32'd0);
        check("t4_clr_keeps_drops", 32'(drop_count), 32'd5);
        for (int i = 0; i < 16; i++) begin
            in_sample = 16'(16'h0100 + i);
            in_valid  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t4_full",      32'(level),    32'd16);
        check("t4_full_ovf",  32'(overflow), 32'd0);
        in_sample = 16'h0200;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_level",    32'(level),      32'd16);
        check("t4_overflow", 32'(overflow),   32'd0);
        check("t4_drops",    32'(drop_count), 32'd5);
        check("t4_head",     32'(out_sample), 32'h0101);
        for (int i = 0; i < 16; i++) begin
            check("t4_drain", 32'(out_sample), (i < 15) ? 32'(16'h0101 + i) : 32'h0200);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("t4_empty", 32'(level), 32'd0);

        // 5: underrun, set-beats-clear, then clear
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_underrun",  32'(underrun), 32'd1);
        check("t5_level",     32'(level),    32'd0);
        out_ready = 1'b1;
        flag_clr  = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_set_wins",  32'(underrun), 32'd1);
        tick();
        flag_clr = 1'b0;
        check("t5_cleared",   32'(underrun), 32'd0);
        check("t5_overflow",  32'(overflow), 32'd0);

        // 6: saturating drop counter, then reset mid-stream
        for (int i = 0; i < 300; i++) begin
            in_sample = 16'(i);
            in_valid  = 1'b1;
            tick();
        end
        check("t6_drops_sat", 32'(drop_count), 32'd255);
        check("t6_level",     32'(level),      32'd16);
        check("t6_overflow",  32'(overflow),   32'd1);
        check("t6_head",      32'(out_sample), 32'd284);
        in_sample = 16'hBEEF;
        reset     = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_state("t6_rst");
        in_sample = 16'h8001;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t6_post_valid",  32'(out_valid),  32'd1);
        check("t6_post_sample", 32'(out_sample), 32'h8001);
        check("t6_post_level",  32'(level),      32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_post_empty",  32'(level),      32'd0);
        check("t6_post_zero",   32'(out_sample), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pcm_sample_fifo
